// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: requester count,
// index/counter widths, FSM state encoding, default hold limit and a
// one-hot helper used when a grant is issued.
package rr_arb_pkg;

   localparam int unsigned NUM_REQ      = 4;
   localparam int unsigned IDX_W        = 2;
   localparam int unsigned HCNT_W       = 8;
   localparam int unsigned DEF_MAX_HOLD = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Binary requester index to one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage : rr_arb_pkg

// File: rtl/rr_prio_enc4.sv
// Rotating priority encoder: finds the first set bit of req scanning
// ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//   req   : request vector, bit n = requester n
//   ptr   : highest-priority requester index
//   valid : any request present
//   index : winning requester index (0 when no request)
module rr_prio_enc4
   import rr_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   logic [IDX_W-1:0] cand;

   // First match in rotated order wins; later candidates are ignored.
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = ptr + IDX_W'(i);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule : rr_prio_enc4

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded grant hold time.
// A grant is released when the owner drops its request, the enable falls,
// or the hold limit is reached; every release is followed by at least one
// idle cycle, and the pointer then moves past the released owner.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   e      : enable; low blocks new grants and releases the current one
//   req    : level requests, bit n = requester n
//   gnt    : registered one-hot grant, zero when idle
//   gnt_id : registered binary index of the grant, zero when idle
//   busy   : registered, high while a grant is active
module rr_arbiter4
   import rr_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               e,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_id,
   output logic               busy
);

   localparam logic [HCNT_W-1:0] HOLD_LIMIT = HCNT_W'(MAX_HOLD);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0]    gnt_id_q, gnt_id_d;
   logic                busy_q, busy_d;

   logic                enc_valid;
   logic [IDX_W-1:0]    enc_idx;
   logic                release_c;

   rr_prio_enc4 u_enc (
      .req   (req),
      .ptr   (ptr_q),
      .valid (enc_valid),
      .index (enc_idx)
   );

   // gnt_id_q names the owner while in GRANT.
   assign release_c = !req[gnt_id_q] || !e || (hcnt_q == HOLD_LIMIT);

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      hcnt_d   = hcnt_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (e && enc_valid) begin
               state_d  = GRANT;
               gnt_d    = idx_to_onehot(enc_idx);
               gnt_id_d = enc_idx;
               busy_d   = 1'b1;
               hcnt_d   = HCNT_W'(1);
            end
         end
         GRANT: begin
            if (release_c) begin
               // Always pass through IDLE, even if requests are pending.
               state_d  = IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
               hcnt_d   = '0;
               ptr_d    = gnt_id_q + IDX_W'(1);
            end else begin
               hcnt_d = hcnt_q + HCNT_W'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
            hcnt_d   = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         hcnt_q   <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         hcnt_q   <= hcnt_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;

endmodule : rr_arbiter4

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning the maximum consecutive cycles one requester may hold the grant (legal 1..255).
REQ-002 clk  input  1  single clock for the block; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 e  input  1  arbiter enable; low blocks new grants and forces release of the current grant.
REQ-005 req  input  4  level request per requester, bit n = requester n.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-007 gnt_id  output  2  binary index of the granted requester, registered; 0 when no grant.
REQ-008 busy  output  1  high while any gnt bit is high.

Function
REQ-009 The arbiter SHALL be a two-state FSM: IDLE (no grant) and GRANT (exactly one gnt bit high).
REQ-010 Round-robin pointer ptr (2 bits) SHALL name the highest-priority requester; priority order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
REQ-011 In IDLE, if e=1 and req!=0 at a clock edge, the FSM SHALL enter GRANT with gnt = one-hot of the first requesting index in priority order; latency is exactly 1 cycle.
REQ-012 In IDLE, if e=0 or req=0, the FSM SHALL stay in IDLE with gnt=0.
REQ-013 In GRANT, hold counter hcnt (8 bits) SHALL be 1 in the first grant cycle and increment by 1 each further cycle the grant is held.
REQ-014 Release SHALL occur on the first edge where any of these holds: req[owner]=0, e=0, or hcnt=MAX_HOLD.
REQ-015 On release, the FSM SHALL go to IDLE, gnt SHALL be 0 on the next cycle, and ptr SHALL become owner+1 mod 4.
REQ-016 A minimum of one all-zero gnt cycle SHALL separate consecutive grants, including re-grant to the same requester.
REQ-017 gnt_id SHALL always equal the binary encoding of gnt (bit 3 -> 3, bit 2 -> 2, bit 1 -> 1, bit 0 -> 0), and busy SHALL equal |gnt.
REQ-018 Changes to non-owner req bits during GRANT SHALL NOT affect gnt, gnt_id, or hcnt.
REQ-019 With MAX_HOLD=1, every grant SHALL last exactly 1 cycle.
REQ-020 Simultaneous release cause and new requests SHALL still yield the IDLE gap cycle; arbitration happens from IDLE using the updated ptr.

Reset
REQ-021 While rst_n=0, the block SHALL asynchronously force state=IDLE, ptr=0, hcnt=0, gnt=0, gnt_id=0, busy=0.
REQ-022 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for clk.
REQ-023 The first arbitration after rst_n rises SHALL use ptr=0, giving requester 0 highest priority.

Structure
REQ-024 Shared package rr_arb_pkg SHALL hold NUM_REQ=4, the state enum {IDLE, GRANT}, and the default MAX_HOLD.
REQ-025 A combinational sub-module rr_prio_enc4 SHALL map (req, ptr) to (valid, index[1:0]) as a rotating priority encoder; all state stays in rr_arbiter4.

Verification
REQ-026 Reset then req=4'b1111 held, MAX_HOLD=8, e=1 -> grants 0,1,2,3,0 in order, each 8 cycles, with a 1-cycle gap between them.
REQ-027 req=4'b0100 for 3 cycles then 0 -> gnt=4'b0100 and gnt_id=2 for 3 cycles, then gnt=0, ptr=3.
REQ-028 Requester 1 granted, then e drops to 0 -> gnt=0 on the next cycle; no new grant while e=0 even with req=4'b1111.
REQ-029 rst_n pulsed low mid-grant, asynchronous to clk -> gnt, gnt_id, and busy go 0 immediately; after release, req=4'b1010 grants requester 1 first.
REQ-030 MAX_HOLD=1, req=4'b1001 held -> gnt alternates 0001, 0000, 1000, 0000, 0001, and so on.
REQ-031 Every cycle the bench SHALL check that gnt is one-hot or zero, that gnt_id matches gnt, and that busy equals |gnt.
